// File: rtl/nn_layer_scheduler.sv
// Layer sequencer for the bit-serial NN datapath: launches one MAC pass per
// layer, steers ReLU beats to activation memory or the output stream, gates
// host weight writes to idle time, and aborts a stalled layer via a watchdog.
module nn_layer_scheduler #(
    parameter int N_LAYERS = 3,
    parameter int N_HIDDEN = 64,
    parameter int WDOG_W   = 16,
    localparam int LAYER_W = $clog2((N_LAYERS > 2) ? N_LAYERS : 2),
    localparam int IDX_W   = $clog2(N_HIDDEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vector_done,
    output logic               in_ready,
    output logic               start_compute,
    output logic [LAYER_W-1:0] layer_idx,
    input  logic               layer_done,
    input  logic               act_valid,
    output logic               act_ready,
    output logic               act_wr_en,
    output logic [IDX_W-1:0]   act_wr_idx,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    input  logic               w_req,
    output logic               w_grant,
    output logic               busy,
    output logic               frame_done,
    output logic               err_count,
    output logic               err_timeout
);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 1);
    localparam logic [IDX_W-1:0]   IDX_FULL   = IDX_W'(N_HIDDEN);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_HIDDEN - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [LAYER_W-1:0] layer_nxt;
    logic [IDX_W-1:0]   idx_nxt, cnt_after;
    logic [WDOG_W-1:0]  wdog, wdog_nxt;
    logic               err_count_nxt, err_timeout_nxt;
    logic               final_layer, beat, last_accept;

    assign final_layer = (layer_idx == LAST_LAYER);

    // Beat steering: hidden layers always sink into activation memory, the
    // final layer passes straight through to the stream with its backpressure.
    always_comb begin
        in_ready      = (state == IDLE);
        busy          = (state != IDLE);
        start_compute = (state == LAUNCH);
        w_grant       = w_req && (state == IDLE) && !vector_done;
        act_ready     = 1'b1;
        act_wr_en     = 1'b0;
        m_tvalid      = 1'b0;
        if (state != IDLE) begin
            if (final_layer) begin
                act_ready = m_tready;
                m_tvalid  = act_valid;
            end else begin
                act_wr_en = act_valid;
            end
        end
        m_tlast     = m_tvalid && (act_wr_idx == IDX_LAST);
        beat        = act_valid && act_ready && (state != IDLE);
        cnt_after   = (beat && (act_wr_idx != IDX_FULL)) ? act_wr_idx + 1'b1 : act_wr_idx;
        last_accept = final_layer && beat && (act_wr_idx == IDX_LAST);
    end

    // Next-state: layer sequencing, frame completion and watchdog abort.
    // If the final layer's beats all land before layer_done, the frame ends
    // (and frame_done pulses) on the layer_done cycle instead.
    always_comb begin
        state_nxt       = state;
        layer_nxt       = layer_idx;
        idx_nxt         = cnt_after;
        wdog_nxt        = wdog;
        err_count_nxt   = err_count;
        err_timeout_nxt = err_timeout;
        frame_done      = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt  = '0;
                wdog_nxt = '0;
                if (vector_done) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                wdog_nxt  = '0;
                state_nxt = RUN;
            end
            default: begin
                wdog_nxt = beat ? '0 : wdog + 1'b1;
                if (wdog == '1) begin
                    state_nxt       = IDLE;
                    layer_nxt       = '0;
                    idx_nxt         = '0;
                    err_timeout_nxt = 1'b1;
                end else if (state == RUN) begin
                    if (layer_done) begin
                        if (!final_layer) begin
                            if (cnt_after != IDX_FULL) err_count_nxt = 1'b1;
                            layer_nxt = layer_idx + 1'b1;
                            idx_nxt   = '0;
                            state_nxt = LAUNCH;
                        end else if (cnt_after == IDX_FULL) begin
                            frame_done = 1'b1;
                            state_nxt  = IDLE;
                            layer_nxt  = '0;
                            idx_nxt    = '0;
                        end else begin
                            state_nxt = DRAIN;
                        end
                    end
                end else if (last_accept) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                    layer_nxt  = '0;
                    idx_nxt    = '0;
                end
            end
        endcase
    end

    // State and counters; reset also discards any in-flight frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            layer_idx   <= '0;
            act_wr_idx  <= '0;
            wdog        <= '0;
            err_count   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            layer_idx   <= layer_nxt;
            act_wr_idx  <= idx_nxt;
            wdog        <= wdog_nxt;
            err_count   <= err_count_nxt;
            err_timeout <= err_timeout_nxt;
        end
    end

endmodule
